// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 64-bit multiply/divide unit for the LEGv8 datapath.
// It computes MUL, UMULH, UDIV or SDIV over a fixed number of cycles. The
// result is presented as a register-file write-back triple (BusW, RW, RegWr).
// While the unit is working, Busy stalls the fetch stage.
//
// Ports:
//   Clk     - clock, rising edge
//   Reset_n - asynchronous active-low reset
//   Start   - operation request, sampled only in IDLE
//   Op      - 00 MUL, 01 UMULH, 10 UDIV, 11 SDIV
//   BusA    - multiplicand / dividend
//   BusB    - multiplier / divisor
//   Rd      - destination register index
//   Busy    - high in CALC and FIX
//   Done    - one-cycle completion pulse (DONE state)
//   BusW    - result to register file
//   RW      - destination index to register file
//   RegWr   - write enable to register file (suppressed for XZR, Rd=31)
module mul_div_unit #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       Rd,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] BusW,
  output logic [4:0]       RW,
  output logic             RegWr
);

  // Edges from the accepting Start edge to the edge that raises Done.
  localparam int LATENCY = WIDTH + 2;
  localparam int CntW    = $clog2(WIDTH + 1);
  // The counter starts one above the last iteration index. That first CALC
  // cycle turns the SDIV operands into magnitudes. The remaining WIDTH
  // cycles iterate, with the counter going from WIDTH-1 down to 0.
  localparam logic [CntW-1:0] PrepCnt = CntW'(LATENCY - 2);

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpUmulh = 2'b01;
  localparam logic [1:0] OpSdiv  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;
  stateT state, stateNext;

  logic [1:0]         opLat;
  logic [4:0]         rdLat;
  logic               signA, signB;
  logic [CntW-1:0]    cnt;
  // Multiply: the 2*WIDTH product. The multiplier sits in the low half and
  // shifts out to the right.
  // Divide: the remainder is in the high half. The dividend sits in the low
  // half, shifts out at the top, and the quotient bits fill in from the
  // bottom.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opB;      // multiplicand / divisor

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     remShift;
  logic               canSub;
  logic [WIDTH-1:0]   remDiff;
  logic [2*WIDTH-1:0] divNext;
  logic [WIDTH-1:0]   result;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next state and status outputs
  always_comb begin
    stateNext = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    RegWr     = 1'b0;
    case (state)
      IDLE: if (Start) stateNext = CALC;
      CALC: begin
        Busy = 1'b1;
        if (cnt == '0) stateNext = FIX;
      end
      FIX: begin
        Busy      = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        RegWr     = (rdLat != 5'd31);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // One radix-2 shift-add step. The carry out of the add becomes the new MSB.
  always_comb begin
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
    mulNext = {mulSum, acc[WIDTH-1:1]};
  end

  // One restoring-division step. When the subtraction succeeds, the
  // difference is below the divisor, so WIDTH bits hold it exactly.
  always_comb begin
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    canSub   = (remShift >= {1'b0, opB});
    remDiff  = remShift[WIDTH-1:0] - opB;
    divNext  = canSub ? {remDiff, acc[WIDTH-2:0], 1'b1}
                      : {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Result selection and sign correction, captured in FIX.
  // For SDIV MIN/-1 the magnitude quotient is 2^(WIDTH-1). Both signs are
  // negative, so no correction applies and the result wraps naturally.
  always_comb begin
    result = acc[WIDTH-1:0];
    case (opLat)
      OpMul:   result = acc[WIDTH-1:0];
      OpUmulh: result = acc[2*WIDTH-1:WIDTH];
      default: begin
        if (opB == '0)
          result = '0;
        else if (opLat == OpSdiv && (signA ^ signB))
          result = -acc[WIDTH-1:0];
        else
          result = acc[WIDTH-1:0];
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      opLat <= '0;
      rdLat <= '0;
      signA <= 1'b0;
      signB <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      opB   <= '0;
      BusW  <= '0;
      RW    <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          opLat <= Op;
          rdLat <= Rd;
          signA <= BusA[WIDTH-1];
          signB <= BusB[WIDTH-1];
          acc   <= {{WIDTH{1'b0}}, BusA};
          opB   <= BusB;
          cnt   <= PrepCnt;
        end
        CALC: begin
          if (cnt == PrepCnt) begin
            if (opLat == OpSdiv) begin
              acc <= {{WIDTH{1'b0}}, (signA ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])};
              opB <= signB ? -opB : opB;
            end
          end else begin
            acc <= opLat[1] ? divNext : mulNext;
          end
          if (cnt != '0) cnt <= cnt - CntW'(1);
        end
        FIX: begin
          BusW <= result;
          RW   <= rdLat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit. Expected write-backs are queued when
// an operation is issued. A monitor pops and compares them when Done pulses.
module tb_mul_div_unit;
  localparam int W = 64;
  localparam int LAT = W + 2;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] BusA = '0;
  logic [W-1:0] BusB = '0;
  logic [4:0]   Rd = '0;
  logic         Busy, Done, RegWr;
  logic [W-1:0] BusW;
  logic [4:0]   RW;

  mul_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op),
    .BusA(BusA), .BusB(BusB), .Rd(Rd),
    .Busy(Busy), .Done(Done), .BusW(BusW), .RW(RW), .RegWr(RegWr)
  );

  always #5 Clk = ~Clk;

  int edgeCnt = 0;
  always @(posedge Clk) edgeCnt <= edgeCnt + 1;

  // Register file fed by the write-back triple
  logic [W-1:0] rf [32];
  always @(posedge Clk) if (RegWr && RW != 5'd31) rf[RW] <= BusW;

  int checkCnt = 0;
  int errCnt = 0;

  logic [W-1:0] expW [$];
  logic [4:0]   expRd [$];
  logic         expWe [$];
  int           expEdge [$];
  string        expTag [$];

  task automatic checkEq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [W-1:0] w, input logic [4:0] rd,
                         input logic we, input int doneEdge);
    expTag.push_back(tag);
    expW.push_back(w);
    expRd.push_back(rd);
    expWe.push_back(we);
    expEdge.push_back(doneEdge);
  endtask

  // Scoreboard monitor: one line per completed transaction
  always @(negedge Clk) begin
    string t;
    if (Reset_n && Done) begin
      if (expW.size() == 0) begin
        checkEq("unexpected_done", Done, 0);
      end else begin
        t = expTag.pop_front();
        $display("txn %s: BusW=0x%h RW=%0d RegWr=%b edge=%0d", t, BusW, RW, RegWr, edgeCnt);
        checkEq({t, "_busw"}, BusW, expW.pop_front());
        checkEq({t, "_rw"}, RW, expRd.pop_front());
        checkEq({t, "_regwr"}, RegWr, expWe.pop_front());
        checkEq({t, "_latency"}, edgeCnt, expEdge.pop_front());
        checkEq({t, "_busy"}, Busy, 0);
      end
    end
  end

  // Called at a negedge while the unit is idle; returns the accepting edge number
  task automatic startOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd, input bit hold, output int accEdge);
    Start = 1'b1; Op = op; BusA = a; BusB = b; Rd = rd;
    @(posedge Clk);
    #1;
    accEdge = edgeCnt;
    if (!hold) Start = 1'b0;
    BusA = ~a;   // operands must be ignored after acceptance
    BusB = ~b;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (Done !== 1'b1 && n < 200);
    if (Done !== 1'b1) checkEq({tag, "_timeout"}, Done, 1);
    @(negedge Clk);
    checkEq({tag, "_regwr_pulse"}, RegWr, 0);
    checkEq({tag, "_done_pulse"}, Done, 0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] rd,
                       input logic [W-1:0] w, input logic we);
    int e;
    startOp(op, a, b, rd, 1'b0, e);
    pushExp(tag, w, rd, we, e + LAT);
    waitDone(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int pulses;

    // Reset state
    repeat (3) @(negedge Clk);
    checkEq("rst_busy", Busy, 0);
    checkEq("rst_done", Done, 0);
    checkEq("rst_regwr", RegWr, 0);
    checkEq("rst_busw", BusW, 0);
    checkEq("rst_rw", RW, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    runOp("mul", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    runOp("umulh", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'h1, 1'b1);

    // Reset in the middle of a UDIV abandons it
    startOp(2'b10, 64'd100, 64'd7, 5'd3, 1'b0, e);
    repeat (10) @(negedge Clk);
    checkEq("calc_busy", Busy, 1);
    Reset_n = 1'b0;
    #1;
    checkEq("midrst_busy", Busy, 0);
    checkEq("midrst_done", Done, 0);
    checkEq("midrst_regwr", RegWr, 0);
    checkEq("midrst_busw", BusW, 0);
    checkEq("midrst_rw", RW, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    pulses = 0;
    repeat (80) begin
      @(negedge Clk);
      if (RegWr || Done) pulses++;
    end
    checkEq("midrst_no_wb", pulses, 0);

    runOp("udiv", 2'b10, 64'd100, 64'd7, 5'd3, 64'd14, 1'b1);
    runOp("sdiv_neg", 2'b11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd6, 64'hFFFF_FFFF_FFFF_FFF2, 1'b1);
    runOp("sdiv_min", 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
          64'h8000_0000_0000_0000, 1'b1);
    runOp("udiv_zero", 2'b10, 64'd1234, 64'd0, 5'd9, 64'd0, 1'b1);
    runOp("mul_xzr", 2'b00, 64'd3, 64'd4, 5'd31, 64'd12, 1'b0);

    // Start pulsed during CALC is ignored
    startOp(2'b10, 64'd1000, 64'd10, 5'd4, 1'b0, e);
    pushExp("midstart", 64'd100, 5'd4, 1'b1, e + LAT);
    repeat (20) @(negedge Clk);
    Start = 1'b1; Op = 2'b00; BusA = 64'd7; BusB = 64'd7; Rd = 5'd11;
    @(negedge Clk);
    Start = 1'b0;
    waitDone("midstart");
    pulses = 0;
    repeat (80) begin
      @(negedge Clk);
      if (Done) pulses++;
    end
    checkEq("midstart_no_second", pulses, 0);

    // Start held high: the second operation is accepted at the first IDLE edge
    startOp(2'b00, 64'd5, 64'd6, 5'd1, 1'b1, e);
    Op = 2'b10; BusA = 64'd90; BusB = 64'd9; Rd = 5'd2;
    pushExp("held1", 64'd30, 5'd1, 1'b1, e + LAT);
    pushExp("held2", 64'd10, 5'd2, 1'b1, e + LAT + 2 + LAT);
    while (edgeCnt < e + LAT + 1) @(negedge Clk);
    checkEq("held_idle_busy", Busy, 0);
    @(negedge Clk);
    checkEq("held_accept_busy", Busy, 1);
    Start = 1'b0;
    waitDone("held2");

    // Write-back reaches the register file
    runOp("rf_mul", 2'b00, 64'h1234_5678, 64'h10, 5'd7, 64'h1_2345_6780, 1'b1);
    checkEq("rf_x7", rf[7], 64'h1_2345_6780);

    checkEq("sb_empty", expW.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
